// File: rtl/ex_stage.sv
// ex_stage: execute stage of the five-stage MIPS pipeline.
// Logic, shift, move and HI/LO moves are combinational; DIV/DIVU use an
// iterative 32-step restoring divider that holds the pipeline via stallreq_o.
// Optional feature macro: DIV_EN (divider compiled in when defined).
module ex_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  aluop_i,
   input  logic [2:0]  alusel_i,
   input  logic [31:0] reg1_i,
   input  logic [31:0] reg2_i,
   input  logic [4:0]  wd_i,
   input  logic        wreg_i,
   input  logic [31:0] hi_i,
   input  logic [31:0] lo_i,
   input  logic        mem_whilo_i,
   input  logic [31:0] mem_hi_i,
   input  logic [31:0] mem_lo_i,
   input  logic        wb_whilo_i,
   input  logic [31:0] wb_hi_i,
   input  logic [31:0] wb_lo_i,
   output logic [4:0]  wd_o,
   output logic        wreg_o,
   output logic [31:0] wdata_o,
   output logic        whilo_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic        stallreq_o
);

   localparam int unsigned DW = 32;

   localparam logic [7:0] EXE_AND_OP  = 8'b00100100;
   localparam logic [7:0] EXE_OR_OP   = 8'b00100101;
   localparam logic [7:0] EXE_XOR_OP  = 8'b00100110;
   localparam logic [7:0] EXE_NOR_OP  = 8'b00100111;
   localparam logic [7:0] EXE_SLL_OP  = 8'b01111100;
   localparam logic [7:0] EXE_SRL_OP  = 8'b00000010;
   localparam logic [7:0] EXE_SRA_OP  = 8'b00000011;
   localparam logic [7:0] EXE_MOVZ_OP = 8'b00001010;
   localparam logic [7:0] EXE_MOVN_OP = 8'b00001011;
   localparam logic [7:0] EXE_MFHI_OP = 8'b00010000;
   localparam logic [7:0] EXE_MTHI_OP = 8'b00010001;
   localparam logic [7:0] EXE_MFLO_OP = 8'b00010010;
   localparam logic [7:0] EXE_MTLO_OP = 8'b00010011;
   localparam logic [7:0] EXE_DIV_OP  = 8'b00011010;
   localparam logic [7:0] EXE_DIVU_OP = 8'b00011011;

   localparam logic [2:0] EXE_RES_NOP   = 3'b000;
   localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
   localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
   localparam logic [2:0] EXE_RES_MOVE  = 3'b011;

   logic [DW-1:0] hi_fwd;
   logic [DW-1:0] lo_fwd;

   // HI/LO forwarding: MEM beats WB beats the committed registers
   always_comb begin
      hi_fwd = hi_i;
      lo_fwd = lo_i;
      if (mem_whilo_i) begin
         hi_fwd = mem_hi_i;
         lo_fwd = mem_lo_i;
      end else if (wb_whilo_i) begin
         hi_fwd = wb_hi_i;
         lo_fwd = wb_lo_i;
      end
   end

`ifdef DIV_EN
   localparam logic [1:0] ST_FREE   = 2'b00;
   localparam logic [1:0] ST_BYZERO = 2'b01;
   localparam logic [1:0] ST_ON     = 2'b10;
   localparam logic [1:0] ST_END    = 2'b11;

   logic [1:0]    state_q, state_d;
   logic [64:0]   rq_q;
   logic [DW-1:0] dvd_q, dvs_q;
   logic [5:0]    cnt_q;
   logic          sgn1_q, sgn2_q, signed_q;
   logic          div_op, div_s, div_end;
   logic [DW-1:0] abs1, abs2, quo_fix, rem_fix;
   logic [33:0]   trial;
   logic          ge;
   logic [32:0]   rem_new;

   assign div_op  = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);
   assign div_s   = (aluop_i == EXE_DIV_OP);
   assign div_end = (state_q == ST_END);
   assign abs1    = (div_s && reg1_i[DW-1]) ? (~reg1_i + 32'd1) : reg1_i;
   assign abs2    = (div_s && reg2_i[DW-1]) ? (~reg2_i + 32'd1) : reg2_i;

   // One restoring step: bring in the next dividend bit, subtract if it fits
   assign trial   = {rq_q[64:32], dvd_q[DW-1]};
   assign ge      = (trial >= {2'b00, dvs_q});
   assign rem_new = ge ? 33'(trial - {2'b00, dvs_q}) : trial[32:0];

   // Signed fix-up: quotient negative on sign mismatch, remainder follows dividend
   assign quo_fix = (signed_q && (sgn1_q ^ sgn2_q)) ? (~rq_q[31:0] + 32'd1) : rq_q[31:0];
   assign rem_fix = (signed_q && sgn1_q) ? (~rq_q[63:32] + 32'd1) : rq_q[63:32];

   // Divider state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_FREE;
      else     state_q <= state_d;
   end

   // Divider next-state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_FREE:   if (div_op) state_d = (reg2_i == '0) ? ST_BYZERO : ST_ON;
         ST_BYZERO: state_d = ST_END;
         ST_ON:     if (cnt_q == 6'd31) state_d = ST_END;
         ST_END:    state_d = ST_FREE;
         default:   state_d = ST_FREE;
      endcase
   end

   // Divider datapath: operand capture in FREE, shift-subtract in ON
   always_ff @(posedge clk) begin
      if (rst) begin
         rq_q     <= '0;
         dvd_q    <= '0;
         dvs_q    <= '0;
         cnt_q    <= '0;
         sgn1_q   <= 1'b0;
         sgn2_q   <= 1'b0;
         signed_q <= 1'b0;
      end else if (state_q == ST_FREE) begin
         if (div_op) begin
            rq_q     <= '0;
            cnt_q    <= '0;
            dvd_q    <= abs1;
            dvs_q    <= abs2;
            sgn1_q   <= reg1_i[DW-1];
            sgn2_q   <= reg2_i[DW-1];
            signed_q <= div_s;
         end
      end else if (state_q == ST_ON) begin
         rq_q  <= {rem_new, rq_q[30:0], ge};
         dvd_q <= {dvd_q[DW-2:0], 1'b0};
         cnt_q <= cnt_q + 6'd1;
      end
   end
`else
   logic unused_clk;
   assign unused_clk = clk;
`endif

   // Result mux and write-back bundle; reset forces every output low
   always_comb begin
      wd_o       = wd_i;
      wreg_o     = wreg_i;
      wdata_o    = '0;
      whilo_o    = 1'b0;
      hi_o       = '0;
      lo_o       = '0;
      stallreq_o = 1'b0;
      case (alusel_i)
         EXE_RES_LOGIC: begin
            case (aluop_i)
               EXE_OR_OP:  wdata_o = reg1_i | reg2_i;
               EXE_AND_OP: wdata_o = reg1_i & reg2_i;
               EXE_XOR_OP: wdata_o = reg1_i ^ reg2_i;
               EXE_NOR_OP: wdata_o = ~(reg1_i | reg2_i);
               default:    wdata_o = '0;
            endcase
         end
         EXE_RES_SHIFT: begin
            case (aluop_i)
               EXE_SLL_OP: wdata_o = reg2_i << reg1_i[4:0];
               EXE_SRL_OP: wdata_o = reg2_i >> reg1_i[4:0];
               EXE_SRA_OP: wdata_o = 32'($signed(reg2_i) >>> reg1_i[4:0]);
               default:    wdata_o = '0;
            endcase
         end
         EXE_RES_MOVE: begin
            case (aluop_i)
               EXE_MFHI_OP: wdata_o = hi_fwd;
               EXE_MFLO_OP: wdata_o = lo_fwd;
               EXE_MOVN_OP: wdata_o = reg1_i;
               EXE_MOVZ_OP: wdata_o = reg1_i;
               default:     wdata_o = '0;
            endcase
         end
         EXE_RES_NOP: wdata_o = '0;
         default:     wdata_o = '0;
      endcase
      case (aluop_i)
         EXE_MOVN_OP: wreg_o = wreg_i & (reg2_i != '0);
         EXE_MOVZ_OP: wreg_o = wreg_i & (reg2_i == '0);
         EXE_MTHI_OP: begin
            whilo_o = 1'b1;
            hi_o    = reg1_i;
            lo_o    = lo_fwd;
         end
         EXE_MTLO_OP: begin
            whilo_o = 1'b1;
            hi_o    = hi_fwd;
            lo_o    = reg1_i;
         end
         EXE_DIV_OP, EXE_DIVU_OP: begin
            wreg_o = 1'b0;
`ifdef DIV_EN
            whilo_o    = div_end;
            hi_o       = div_end ? rem_fix : '0;
            lo_o       = div_end ? quo_fix : '0;
            stallreq_o = !div_end;
`endif
         end
         default: ;
      endcase
      if (rst) begin
         wd_o       = '0;
         wreg_o     = 1'b0;
         wdata_o    = '0;
         whilo_o    = 1'b0;
         hi_o       = '0;
         lo_o       = '0;
         stallreq_o = 1'b0;
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: driver queues expected outputs per cycle,
// monitor pops and compares on the falling edge. Follows DIV_EN like the RTL.
module tb_ex_stage;

   localparam logic [7:0] OP_AND  = 8'b00100100;
   localparam logic [7:0] OP_OR   = 8'b00100101;
   localparam logic [7:0] OP_XOR  = 8'b00100110;
   localparam logic [7:0] OP_NOR  = 8'b00100111;
   localparam logic [7:0] OP_SLL  = 8'b01111100;
   localparam logic [7:0] OP_SRL  = 8'b00000010;
   localparam logic [7:0] OP_SRA  = 8'b00000011;
   localparam logic [7:0] OP_MOVZ = 8'b00001010;
   localparam logic [7:0] OP_MOVN = 8'b00001011;
   localparam logic [7:0] OP_MFHI = 8'b00010000;
   localparam logic [7:0] OP_MTHI = 8'b00010001;
   localparam logic [7:0] OP_MFLO = 8'b00010010;
   localparam logic [7:0] OP_MTLO = 8'b00010011;
   localparam logic [7:0] OP_DIV  = 8'b00011010;
   localparam logic [7:0] OP_DIVU = 8'b00011011;

   localparam logic [2:0] SEL_NOP   = 3'b000;
   localparam logic [2:0] SEL_LOGIC = 3'b001;
   localparam logic [2:0] SEL_SHIFT = 3'b010;
   localparam logic [2:0] SEL_MOVE  = 3'b011;

   typedef struct packed {
      logic        rst;
      logic [7:0]  aluop;
      logic [2:0]  alusel;
      logic [31:0] reg1, reg2;
      logic [4:0]  wd;
      logic        wreg;
      logic [31:0] hi, lo;
      logic        mw;
      logic [31:0] mhi, mlo;
      logic        ww;
      logic [31:0] whi, wlo;
   } stim_t;

   typedef struct packed {
      logic [4:0]  wd;
      logic        wreg;
      logic [31:0] wdata;
      logic        whilo;
      logic [31:0] hi, lo;
      logic        stall;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  aluop_i;
   logic [2:0]  alusel_i;
   logic [31:0] reg1_i, reg2_i, hi_i, lo_i, mem_hi_i, mem_lo_i, wb_hi_i, wb_lo_i;
   logic [4:0]  wd_i;
   logic        wreg_i, mem_whilo_i, wb_whilo_i;
   logic [4:0]  wd_o;
   logic        wreg_o, whilo_o, stallreq_o;
   logic [31:0] wdata_o, hi_o, lo_o;

   exp_t  exp_q[$];
   string name_q[$];
   int    n_checks = 0;
   int    n_pass   = 0;

   always #5 clk = ~clk;

   ex_stage dut (
      .clk(clk), .rst(rst), .aluop_i(aluop_i), .alusel_i(alusel_i),
      .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
      .hi_i(hi_i), .lo_i(lo_i),
      .mem_whilo_i(mem_whilo_i), .mem_hi_i(mem_hi_i), .mem_lo_i(mem_lo_i),
      .wb_whilo_i(wb_whilo_i), .wb_hi_i(wb_hi_i), .wb_lo_i(wb_lo_i),
      .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .whilo_o(whilo_o),
      .hi_o(hi_o), .lo_o(lo_o), .stallreq_o(stallreq_o)
   );

   function automatic stim_t st(input logic [7:0] op, input logic [2:0] sel,
                                input logic [31:0] a, input logic [31:0] b);
      stim_t s;
      s        = '0;
      s.aluop  = op;
      s.alusel = sel;
      s.reg1   = a;
      s.reg2   = b;
      s.wd     = 5'd3;
      s.wreg   = 1'b1;
      s.hi     = 32'h11;
      s.lo     = 32'h22;
      return s;
   endfunction

   function automatic exp_t ex(input logic wreg, input logic [31:0] wdata, input logic whilo,
                               input logic [31:0] hi, input logic [31:0] lo, input logic stall);
      exp_t e;
      e.wd    = 5'd3;
      e.wreg  = wreg;
      e.wdata = wdata;
      e.whilo = whilo;
      e.hi    = hi;
      e.lo    = lo;
      e.stall = stall;
      return e;
   endfunction

   task automatic apply(input stim_t s);
      rst         = s.rst;
      aluop_i     = s.aluop;
      alusel_i    = s.alusel;
      reg1_i      = s.reg1;
      reg2_i      = s.reg2;
      wd_i        = s.wd;
      wreg_i      = s.wreg;
      hi_i        = s.hi;
      lo_i        = s.lo;
      mem_whilo_i = s.mw;
      mem_hi_i    = s.mhi;
      mem_lo_i    = s.mlo;
      wb_whilo_i  = s.ww;
      wb_hi_i     = s.whi;
      wb_lo_i     = s.wlo;
   endtask

   // Present one cycle of stimulus and queue what the outputs must be in that cycle
   task automatic drive(input stim_t s, input exp_t e, input string nm);
      @(posedge clk);
      #1;
      apply(s);
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

`ifdef DIV_EN
   // Full divide: n_stall stalled cycles (operands scrambled after cycle 0), then END
   task automatic div_seq(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int n_stall, input logic [31:0] eh, input logic [31:0] el,
                          input string nm);
      stim_t s;
      for (int c = 0; c < n_stall; c++) begin
         s = st(op, SEL_NOP, a, b);
         if (c > 0) begin
            s.reg1 = a ^ 32'hFFFF_0000;
            s.reg2 = 32'h0;
         end
         drive(s, ex(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1), nm);
      end
      drive(st(op, SEL_NOP, a, b), ex(1'b0, 32'h0, 1'b1, eh, el, 1'b0), {nm, "_end"});
   endtask
`endif

   // Monitor: compare the DUT against the oldest queued expectation each cycle
   initial begin
      exp_t  e, act;
      string nm;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            act = '{wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o};
            n_checks++;
            if (act === e) n_pass++;
            else $display("FAIL %s: got wd=%0d wreg=%b wdata=%h whilo=%b hi=%h lo=%h stall=%b; want wd=%0d wreg=%b wdata=%h whilo=%b hi=%h lo=%h stall=%b",
                          nm, act.wd, act.wreg, act.wdata, act.whilo, act.hi, act.lo, act.stall,
                          e.wd, e.wreg, e.wdata, e.whilo, e.hi, e.lo, e.stall);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d checks pending", exp_q.size());
      $fatal(1, "watchdog");
   end

   // Directed stimulus
   initial begin
      stim_t s;
      s = st(OP_OR, SEL_NOP, 32'h0, 32'h0);
      s.rst = 1'b1;
      apply(s);
      repeat (2) @(posedge clk);

      s = st(OP_OR, SEL_LOGIC, 32'hFFFF_FFFF, 32'h1234);
      s.rst = 1'b1;
      s.mw = 1'b1;
      drive(s, '0, "reset_outputs");

      drive(st(OP_OR, SEL_LOGIC, 32'h0000FF00, 32'h00F0F0F0),
            ex(1'b1, 32'h00F0FFF0, 1'b0, 32'h0, 32'h0, 1'b0), "or");
      drive(st(OP_AND, SEL_LOGIC, 32'hF0F0F0F0, 32'h0FF00FF0),
            ex(1'b1, 32'h00F000F0, 1'b0, 32'h0, 32'h0, 1'b0), "and");
      drive(st(OP_XOR, SEL_LOGIC, 32'hFFFF0000, 32'h0F0F0F0F),
            ex(1'b1, 32'hF0F00F0F, 1'b0, 32'h0, 32'h0, 1'b0), "xor");
      drive(st(OP_NOR, SEL_LOGIC, 32'h0F0F0000, 32'h000000F0),
            ex(1'b1, 32'hF0F0FF0F, 1'b0, 32'h0, 32'h0, 1'b0), "nor");
      drive(st(OP_SLL, SEL_SHIFT, 32'h00000108, 32'h000000AB),
            ex(1'b1, 32'h0000AB00, 1'b0, 32'h0, 32'h0, 1'b0), "sll");
      drive(st(OP_SRL, SEL_SHIFT, 32'd4, 32'h80000000),
            ex(1'b1, 32'h08000000, 1'b0, 32'h0, 32'h0, 1'b0), "srl");
      drive(st(OP_SRA, SEL_SHIFT, 32'd4, 32'h80000000),
            ex(1'b1, 32'hF8000000, 1'b0, 32'h0, 32'h0, 1'b0), "sra");

      s = st(OP_MTHI, SEL_NOP, 32'h12345678, 32'h0);
      s.wreg = 1'b0;
      s.mw = 1'b1; s.mhi = 32'h99; s.mlo = 32'hAA;
      s.ww = 1'b1; s.whi = 32'h66; s.wlo = 32'hBB;
      drive(s, ex(1'b0, 32'h0, 1'b1, 32'h12345678, 32'hAA, 1'b0), "mthi_mem_fwd");

      s = st(OP_MTLO, SEL_NOP, 32'h55, 32'h0);
      s.wreg = 1'b0;
      s.ww = 1'b1; s.whi = 32'h77; s.wlo = 32'h88;
      drive(s, ex(1'b0, 32'h0, 1'b1, 32'h77, 32'h55, 1'b0), "mtlo_wb_fwd");

      s = st(OP_MFHI, SEL_MOVE, 32'h0, 32'h0);
      s.ww = 1'b1; s.whi = 32'h5; s.wlo = 32'h6;
      drive(s, ex(1'b1, 32'h5, 1'b0, 32'h0, 32'h0, 1'b0), "mfhi_wb_fwd");

      s = st(OP_MFLO, SEL_MOVE, 32'h0, 32'h0);
      s.mw = 1'b1; s.mlo = 32'hCC;
      s.ww = 1'b1; s.wlo = 32'hDD;
      drive(s, ex(1'b1, 32'hCC, 1'b0, 32'h0, 32'h0, 1'b0), "mflo_mem_priority");

      drive(st(OP_MFHI, SEL_MOVE, 32'h0, 32'h0),
            ex(1'b1, 32'h11, 1'b0, 32'h0, 32'h0, 1'b0), "mfhi_committed");
      drive(st(OP_MOVZ, SEL_MOVE, 32'hCAFE, 32'h0),
            ex(1'b1, 32'hCAFE, 1'b0, 32'h0, 32'h0, 1'b0), "movz_taken");
      drive(st(OP_MOVZ, SEL_MOVE, 32'hCAFE, 32'd3),
            ex(1'b0, 32'hCAFE, 1'b0, 32'h0, 32'h0, 1'b0), "movz_not_taken");
      drive(st(OP_MOVN, SEL_MOVE, 32'hBEEF, 32'd3),
            ex(1'b1, 32'hBEEF, 1'b0, 32'h0, 32'h0, 1'b0), "movn_taken");
      drive(st(OP_MOVN, SEL_MOVE, 32'hBEEF, 32'h0),
            ex(1'b0, 32'hBEEF, 1'b0, 32'h0, 32'h0, 1'b0), "movn_not_taken");
      drive(st(OP_OR, 3'b111, 32'h1, 32'h2),
            ex(1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0), "unknown_sel");

`ifdef DIV_EN
      div_seq(OP_DIV, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_m7_2");
      drive(st(OP_OR, SEL_LOGIC, 32'h1, 32'h2),
            ex(1'b1, 32'h3, 1'b0, 32'h0, 32'h0, 1'b0), "or_after_div");
      div_seq(OP_DIVU, 32'd100, 32'd7, 33, 32'd2, 32'd14, "divu_100_7");
      div_seq(OP_DIVU, 32'hFFFFFFFF, 32'h10, 33, 32'hF, 32'h0FFFFFFF, "divu_back_to_back");
      div_seq(OP_DIVU, 32'd5, 32'd0, 2, 32'h0, 32'h0, "divu_by_zero");
      for (int c = 0; c < 10; c++)
         drive(st(OP_DIV, SEL_NOP, 32'd20, 32'hFFFFFFFA),
               ex(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1), "div_pre_reset");
      s = st(OP_DIV, SEL_NOP, 32'd20, 32'hFFFFFFFA);
      s.rst = 1'b1;
      drive(s, '0, "div_reset_cycle");
      div_seq(OP_DIV, 32'd20, 32'hFFFFFFFA, 33, 32'd2, 32'hFFFFFFFD, "div_restart");
`else
      drive(st(OP_DIV, SEL_NOP, 32'hFFFFFFF9, 32'd2),
            ex(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0), "div_disabled");
      drive(st(OP_DIVU, SEL_NOP, 32'd100, 32'd7),
            ex(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0), "divu_disabled");
      drive(st(OP_DIVU, SEL_NOP, 32'd5, 32'd0),
            ex(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0), "divu_zero_disabled");
`endif

      drive(st(OP_AND, SEL_LOGIC, 32'hFF, 32'h0F),
            ex(1'b1, 32'h0F, 1'b0, 32'h0, 32'h0, 1'b0), "and_final");

      repeat (3) @(posedge clk);
      if (exp_q.size() != 0) begin
         n_checks++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
